// File: rtl/dt1_mainfsm.sv
// Multicycle main controller for the RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives datapath muxes and write enables.
//
// Ports:
//   clk, reset            - core clock, async active-high reset (to FETCH)
//   op                    - opcode field of the instruction register
//   BrCond                - ALU branch-condition flag
//   MemReady              - memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite - datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc   - datapath mux controls
//   IllegalInstr          - one-cycle pulse on an unsupported opcode
//   state                 - current state for debug/trace
module dt1_mainfsm #(
  parameter bit FENCE_AS_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       BrCond,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalInstr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_UTYPE    = 4'd13,
    S_ILLEGAL  = 4'd14,
    S_UNUSED   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  state_t state_q, state_d;
  logic   pc_update, branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
          OP_FENCE:
            state_d = FENCE_AS_NOP ? S_FETCH : S_ILLEGAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      // op[5] separates stores from loads
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL,
      S_JALR2, S_UTYPE:          state_d = S_ALUWB;
      S_JALR1:    state_d = S_JALR2;
      S_MEMWB, S_ALUWB,
      S_BRANCH, S_ILLEGAL:       state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode
  always_comb begin
    pc_update    = 1'b0;
    branch       = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    RegWrite     = 1'b0;
    IllegalInstr = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR, S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      // lui adds to zero, auipc adds to OldPC
      S_UTYPE: begin
        ALUSrcA = op[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
      S_ILLEGAL: IllegalInstr = 1'b1;
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & BrCond);

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BR:            ImmSrc = 3'b010;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
      OP_JAL:           ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
    if (state_q == S_UNUSED) ImmSrc = 3'b000;
  end

endmodule
